pipe_ctrl_tracker: RTL and testbench
====================================

// Module: pipe_ctrl_tracker
// PURPOSE
//  Parametrised replacement for the per-stage E/M/W instruction re-decoders.
//  - Decodes each D-stage instruction once.
//  - Carries the destination info (A3, Tnew, regwrite, write-data select) through STAGES pipeline slots.
//  - Counts Tnew down per stage and raises the D-stage stall request for the hazard unit.
//  - The final slot drives the W-stage register-file write controls and a retired-instruction counter.
// PARAMETERS
//  STAGES   3   tracked slots after D (slot 0=E ... slot STAGES-1=W); legal 2..6
//  TNEW_W   2   Tnew field width; counts saturate at 0
//  CNT_W    32  width of the retired-instruction counter
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            asynchronous, active-high; clears all slots and the counter
//  d_instr      in   32           instruction currently in D
//  d_valid      in   1            D holds a real instruction (0 = bubble)
//  d_tuse_rs    in   2            cycles until D's instruction needs rs (3 = never)
//  d_tuse_rt    in   2            cycles until D's instruction needs rt (3 = never)
//  flush        in   1            exception/eret: all slots become bubbles at the next edge
//  stall_req    out  1            combinational: D must hold and E gets a bubble
//  slot_a3      out  5*STAGES     packed destination register per slot, slot 0 in LSBs
//  slot_tnew    out  TNEW_W*STAGES packed Tnew per slot
//  slot_rw      out  STAGES       regwrite per slot
//  w_rw         out  1            final-slot regwrite
//  w_a3         out  5            final-slot destination register
//  w_wdsel      out  2            final-slot write-data select: 0 ALU, 1 MEM, 2 PC+8, 3 CP0
//  retired_cnt  out  CNT_W        count of valid instructions that left the final slot
// BEHAVIOUR
//  - Reset (async, immediate): every slot is a bubble (a3=0, tnew=0, rw=0, wdsel=0, valid=0); retired_cnt=0.
//    While the slots are empty, stall_req=0.
//  - Decode of d_instr, giving the Tnew loaded into slot 0:
//    - ALU R-type, immediate ALU ops and lui: A3=rd for R-type, rt otherwise; Tnew=1; wdsel=ALU.
//    - lw/lh/lhu/lb/lbu: A3=rt; Tnew=2; wdsel=MEM.
//    - mfc0: A3=rt; Tnew=2; wdsel=CP0.
//    - jal: A3=31; Tnew=0; wdsel=PC+8. jalr: A3=rd; Tnew=0; wdsel=PC+8.
//    - Stores, branches, j, jr, mtc0, eret and unknown encodings: rw=0, A3=0.
//    - A3 of 0 always forces rw=0.
//  - Each edge, with no stall and no flush: slot0 <= decode(d_instr) if d_valid, else bubble.
//    Slot i <= slot i-1 with tnew = max(tnew-1, 0). Latency from D to W is STAGES edges.
//  - stall_req=1 when d_valid and some slot i has rw=1, a3!=0 and either:
//    - a3==rs and tnew > d_tuse_rs, or
//    - a3==rt and tnew > d_tuse_rt.
//  - On stall_req: slot0 <= bubble and slots 1..STAGES-1 advance normally.
//  - flush: all slots <= bubble at the next edge. Flush beats stall.
//    The final-slot instruction present in the flush cycle still commits and is counted.
//  - retired_cnt increments on every edge where the final slot is valid (not a bubble); wraps modulo 2^CNT_W.
//  - Reset asserted mid-stream discards all in-flight slots with no partial commit.
// CONFIGURATION
//  HILO_EN defined:
//    - mfhi/mflo decode as A3=rd, Tnew=1, wdsel=ALU.
//    - mult/multu/div/divu/mthi/mtlo decode as rw=0 (tracked, non-writing).
//  HILO_EN undefined: all six HI/LO encodings decode as unknown (rw=0).
// STRUCTURE
//  Shared package pipe_ctrl_pkg holds:
//    - opcode/funct/rs-field constants (including cop0 mfc0/mtc0/eret);
//    - the wdsel enum;
//    - the struct {a3, tnew, rw, wdsel, valid} slot_t and a BUBBLE constant.
//  Sub-module instr_dest_decoder: purely combinational, maps instr to slot_t.
//    It is instantiated once and is reusable by the hazard unit.
// TESTING
//  1. Reset high mid-stream with 3 slots valid: all outputs 0 immediately; retired_cnt=0.
//  2. addu $3 in D, d_valid=1: after 1 edge slot_a3[0]=3, tnew=1; after 3 edges w_a3=3, w_rw=1, w_wdsel=0.
//  3. lw $5 enters slot0 (tnew=2); next D has rs=5 and d_tuse_rs=0:
//     stall_req=1 for 2 cycles, then 0; slot0 is a bubble during the stall.
//  4. jal: slot0 a3=31, tnew=0, wdsel=2; the dependent instruction in D with d_tuse_rs=0 sees stall_req=0.
//  5. flush and stall together with 3 valid slots: next edge all slots are bubbles;
//     retired_cnt increments by exactly 1.
//  6. HILO_EN undefined: mflo $7 gives w_rw=0. HILO_EN defined: mflo $7 gives w_rw=1, w_a3=7.
//     Also preload retired_cnt to 2^CNT_W-1 and retire one instruction: counter wraps to 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, write-data select enum and the per-slot destination record
// used by the pipeline control tracker and the hazard unit.
package pipe_ctrl_pkg;

   localparam int DEC_TNEW_W = 2;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0a;
   localparam logic [5:0] OP_SLTIU   = 6'h0b;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_XORI    = 6'h0e;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_COP0    = 6'h10;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_SLLV  = 6'h04;
   localparam logic [5:0] F_SRLV  = 6'h06;
   localparam logic [5:0] F_SRAV  = 6'h07;
   localparam logic [5:0] F_JALR  = 6'h09;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2a;
   localparam logic [5:0] F_SLTU  = 6'h2b;

   localparam logic [4:0] RS_MFC0 = 5'h00;
   localparam logic [4:0] RS_MTC0 = 5'h04;
   localparam logic [4:0] RS_CO   = 5'h10;

   localparam logic [DEC_TNEW_W-1:0] TNEW_ZERO = 2'd0;
   localparam logic [DEC_TNEW_W-1:0] TNEW_ALU  = 2'd1;
   localparam logic [DEC_TNEW_W-1:0] TNEW_LOAD = 2'd2;

   typedef enum logic [1:0] {
      WD_ALU = 2'd0,
      WD_MEM = 2'd1,
      WD_PC8 = 2'd2,
      WD_CP0 = 2'd3
   } wdsel_e;

   typedef struct packed {
      logic [4:0]            a3;
      logic [DEC_TNEW_W-1:0] tnew;
      logic                  rw;
      wdsel_e                wdsel;
      logic                  valid;
   } slot_t;

   localparam slot_t BUBBLE = '{a3: 5'd0, tnew: 2'd0, rw: 1'b0, wdsel: WD_ALU, valid: 1'b0};

endpackage

// File: rtl/instr_dest_decoder.sv
// Combinational map from a 32-bit instruction to its destination record.
// Defining HILO_EN makes mfhi/mflo register writers; otherwise HI/LO encodings are unknown.
module instr_dest_decoder
   import pipe_ctrl_pkg::*;
(
   input  logic [31:0] instr_i,
   output slot_t       dest_o
);

   logic [5:0] op_s;
   logic [5:0] funct_s;
   logic [4:0] rs_s;
   logic [4:0] rt_s;
   logic [4:0] rd_s;
   logic       unused_shamt_s;
   slot_t      raw_s;

   assign op_s           = instr_i[31:26];
   assign rs_s           = instr_i[25:21];
   assign rt_s           = instr_i[20:16];
   assign rd_s           = instr_i[15:11];
   assign funct_s        = instr_i[5:0];
   assign unused_shamt_s = ^instr_i[10:6];

   // Classify the encoding and pick destination, Tnew and write-data source
   always_comb begin
      raw_s       = BUBBLE;
      raw_s.valid = 1'b1;
      case (op_s)
         OP_SPECIAL: begin
            case (funct_s)
               F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
               F_SLT, F_SLTU: begin
                  raw_s.a3 = rd_s; raw_s.tnew = TNEW_ALU; raw_s.rw = 1'b1; raw_s.wdsel = WD_ALU;
               end
               F_JALR: begin
                  raw_s.a3 = rd_s; raw_s.tnew = TNEW_ZERO; raw_s.rw = 1'b1; raw_s.wdsel = WD_PC8;
               end
`ifdef HILO_EN
               F_MFHI, F_MFLO: begin
                  raw_s.a3 = rd_s; raw_s.tnew = TNEW_ALU; raw_s.rw = 1'b1; raw_s.wdsel = WD_ALU;
               end
               F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: raw_s.rw = 1'b0;
`endif
               default: raw_s.rw = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            raw_s.a3 = rt_s; raw_s.tnew = TNEW_ALU; raw_s.rw = 1'b1; raw_s.wdsel = WD_ALU;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            raw_s.a3 = rt_s; raw_s.tnew = TNEW_LOAD; raw_s.rw = 1'b1; raw_s.wdsel = WD_MEM;
         end
         OP_JAL: begin
            raw_s.a3 = 5'd31; raw_s.tnew = TNEW_ZERO; raw_s.rw = 1'b1; raw_s.wdsel = WD_PC8;
         end
         OP_COP0: begin
            case (rs_s)
               RS_MFC0: begin
                  raw_s.a3 = rt_s; raw_s.tnew = TNEW_LOAD; raw_s.rw = 1'b1; raw_s.wdsel = WD_CP0;
               end
               RS_MTC0: raw_s.rw = 1'b0;
               RS_CO:   raw_s.rw = 1'b0;
               default: raw_s.rw = 1'b0;
            endcase
         end
         default: raw_s.rw = 1'b0;
      endcase
   end

   // Anything not writing a real register is carried as a clean non-writer
   always_comb begin
      dest_o = raw_s;
      if (raw_s.rw && (raw_s.a3 != 5'd0)) begin
         dest_o = raw_s;
      end else begin
         dest_o       = BUBBLE;
         dest_o.valid = raw_s.valid;
      end
   end

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// Decodes the D-stage instruction once and carries its destination record through
// STAGES slots (E..W), generating the D-stage stall request. HILO_EN selects HI/LO decode.
module pipe_ctrl_tracker
   import pipe_ctrl_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int TNEW_W = 2,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                d_instr,
   input  logic                       d_valid,
   input  logic [1:0]                 d_tuse_rs,
   input  logic [1:0]                 d_tuse_rt,
   input  logic                       flush,
   output logic                       stall_req,
   output logic [5*STAGES-1:0]        slot_a3,
   output logic [TNEW_W*STAGES-1:0]   slot_tnew,
   output logic [STAGES-1:0]          slot_rw,
   output logic                       w_rw,
   output logic [4:0]                 w_a3,
   output logic [1:0]                 w_wdsel,
   output logic [CNT_W-1:0]           retired_cnt
);

   logic [4:0]        a3_q    [STAGES];
   logic [4:0]        a3_d    [STAGES];
   logic [TNEW_W-1:0] tnew_q  [STAGES];
   logic [TNEW_W-1:0] tnew_d  [STAGES];
   wdsel_e            wdsel_q [STAGES];
   wdsel_e            wdsel_d [STAGES];
   logic [STAGES-1:0] rw_q, rw_d;
   logic [STAGES-1:0] valid_q, valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   slot_t      dec_s;
   logic [4:0] rs_s;
   logic [4:0] rt_s;
   logic       hit_s;

   assign rs_s = d_instr[25:21];
   assign rt_s = d_instr[20:16];

   instr_dest_decoder u_dec (
      .instr_i (d_instr),
      .dest_o  (dec_s)
   );

   // A D-stage source is stalled while an older producer's result arrives later than needed
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         if (rw_q[i] && (a3_q[i] != 5'd0) &&
             (((a3_q[i] == rs_s) && (32'(tnew_q[i]) > 32'(d_tuse_rs))) ||
              ((a3_q[i] == rt_s) && (32'(tnew_q[i]) > 32'(d_tuse_rt))))) begin
            hit_s = 1'b1;
         end else begin
            hit_s = hit_s;
         end
      end
      stall_req = d_valid && hit_s;
   end

   // Slot advance: older slots always move on; slot 0 takes D unless stalled or flushed
   always_comb begin
      cnt_d   = cnt_q + CNT_W'(valid_q[STAGES-1]);
      rw_d    = '0;
      valid_d = '0;
      for (int i = 0; i < STAGES; i++) begin
         a3_d[i]    = 5'd0;
         tnew_d[i]  = '0;
         wdsel_d[i] = WD_ALU;
      end
      if (flush) begin
         rw_d    = '0;
         valid_d = '0;
      end else begin
         for (int i = 1; i < STAGES; i++) begin
            a3_d[i]    = a3_q[i-1];
            rw_d[i]    = rw_q[i-1];
            wdsel_d[i] = wdsel_q[i-1];
            valid_d[i] = valid_q[i-1];
            tnew_d[i]  = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TNEW_W'(1);
         end
         if (d_valid && !stall_req) begin
            a3_d[0]    = dec_s.a3;
            tnew_d[0]  = TNEW_W'(dec_s.tnew);
            rw_d[0]    = dec_s.rw;
            wdsel_d[0] = dec_s.wdsel;
            valid_d[0] = dec_s.valid;
         end else begin
            rw_d[0]    = 1'b0;
            valid_d[0] = 1'b0;
         end
      end
   end

   // Slot and retired-counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            a3_q[i]    <= 5'd0;
            tnew_q[i]  <= '0;
            wdsel_q[i] <= WD_ALU;
         end
         rw_q    <= '0;
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            a3_q[i]    <= a3_d[i];
            tnew_q[i]  <= tnew_d[i];
            wdsel_q[i] <= wdsel_d[i];
         end
         rw_q    <= rw_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Pack per-slot state onto the flat output buses, slot 0 in the LSBs
   always_comb begin
      slot_a3   = '0;
      slot_tnew = '0;
      for (int i = 0; i < STAGES; i++) begin
         slot_a3[5*i +: 5]           = a3_q[i];
         slot_tnew[TNEW_W*i +: TNEW_W] = tnew_q[i];
      end
   end

   assign slot_rw     = rw_q;
   assign w_rw        = rw_q[STAGES-1];
   assign w_a3        = a3_q[STAGES-1];
   assign w_wdsel     = wdsel_q[STAGES-1];
   assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Self-checking bench for pipe_ctrl_tracker: directed cases plus random stream vs a slot-age model.
module tb_pipe_ctrl_tracker;

   localparam int S  = 3;
   localparam int TW = 2;
`ifdef HILO_EN
   localparam bit HILO = 1'b1;
`else
   localparam bit HILO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   d_instr = 32'd0;
   logic          d_valid = 1'b0;
   logic [1:0]    d_tuse_rs = 2'd3;
   logic [1:0]    d_tuse_rt = 2'd3;
   logic          flush = 1'b0;

   logic          stall_req, w_rw;
   logic [5*S-1:0]  slot_a3;
   logic [TW*S-1:0] slot_tnew;
   logic [S-1:0]  slot_rw;
   logic [4:0]    w_a3;
   logic [1:0]    w_wdsel;
   logic [31:0]   retired_cnt;

   logic          sm_stall, sm_w_rw;
   logic [5*S-1:0]  sm_a3;
   logic [TW*S-1:0] sm_tnew;
   logic [S-1:0]  sm_rw;
   logic [4:0]    sm_w_a3;
   logic [1:0]    sm_w_wdsel;
   logic [2:0]    sm_retired;

   always #5 clk = ~clk;

   pipe_ctrl_tracker #(.STAGES(S), .TNEW_W(TW), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .d_instr(d_instr), .d_valid(d_valid),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .flush(flush),
      .stall_req(stall_req), .slot_a3(slot_a3), .slot_tnew(slot_tnew), .slot_rw(slot_rw),
      .w_rw(w_rw), .w_a3(w_a3), .w_wdsel(w_wdsel), .retired_cnt(retired_cnt));

   pipe_ctrl_tracker #(.STAGES(S), .TNEW_W(TW), .CNT_W(3)) dut_small (
      .clk(clk), .reset(reset), .d_instr(d_instr), .d_valid(d_valid),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .flush(flush),
      .stall_req(sm_stall), .slot_a3(sm_a3), .slot_tnew(sm_tnew), .slot_rw(sm_rw),
      .w_rw(sm_w_rw), .w_a3(sm_w_a3), .w_wdsel(sm_w_wdsel), .retired_cnt(sm_retired));

   int checks = 0;
   int failures = 0;

   // Model: each slot remembers the decoded record; Tnew follows from the slot's age.
   int m_valid [S];
   int m_a3    [S];
   int m_t0    [S];
   int m_rw    [S];
   int m_wd    [S];
   bit [31:0] m_cnt;
   bit [2:0]  m_cnt_s;
   logic      obs_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_decode(input logic [31:0] ins, output int a3, output int t0,
                                      output int rw, output int wd);
      int op, rs, rt, rd, fn;
      op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
      rd = int'(ins[15:11]); fn = int'(ins[5:0]);
      a3 = 0; t0 = 0; rw = 0; wd = 0;
      if (op == 0 && (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43})) begin
         a3 = rd; t0 = 1; rw = 1; wd = 0;
      end else if (op == 0 && fn == 9) begin
         a3 = rd; t0 = 0; rw = 1; wd = 2;
      end else if (op == 0 && HILO && (fn inside {16, 18})) begin
         a3 = rd; t0 = 1; rw = 1; wd = 0;
      end else if (op inside {[8:15]}) begin
         a3 = rt; t0 = 1; rw = 1; wd = 0;
      end else if (op inside {32, 33, 35, 36, 37}) begin
         a3 = rt; t0 = 2; rw = 1; wd = 1;
      end else if (op == 3) begin
         a3 = 31; t0 = 0; rw = 1; wd = 2;
      end else if (op == 16 && rs == 0) begin
         a3 = rt; t0 = 2; rw = 1; wd = 3;
      end
      if (a3 == 0) begin
         t0 = 0; rw = 0; wd = 0;
      end
   endfunction

   function automatic int tn(input int i);
      return (m_t0[i] - i > 0) ? (m_t0[i] - i) : 0;
   endfunction

   function automatic bit exp_stall();
      int rs, rt;
      bit s;
      rs = int'(d_instr[25:21]);
      rt = int'(d_instr[20:16]);
      s = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (m_rw[i] != 0 && m_a3[i] != 0 &&
             ((m_a3[i] == rs && tn(i) > int'(d_tuse_rs)) || (m_a3[i] == rt && tn(i) > int'(d_tuse_rt))))
            s = 1'b1;
      end
      return d_valid && s;
   endfunction

   task automatic clr_slot(input int i);
      m_valid[i] = 0; m_a3[i] = 0; m_t0[i] = 0; m_rw[i] = 0; m_wd[i] = 0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < S; i++) clr_slot(i);
      m_cnt = 32'd0;
      m_cnt_s = 3'd0;
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < S; i++) begin
         chk($sformatf("%s_a3_%0d", tag, i), 64'(slot_a3[5*i +: 5]), 64'(m_a3[i]));
         chk($sformatf("%s_tnew_%0d", tag, i), 64'(slot_tnew[TW*i +: TW]), 64'(tn(i)));
         chk($sformatf("%s_rw_%0d", tag, i), 64'(slot_rw[i]), 64'(m_rw[i]));
      end
      chk({tag, "_w_rw"}, 64'(w_rw), 64'(m_rw[S-1]));
      chk({tag, "_w_a3"}, 64'(w_a3), 64'(m_a3[S-1]));
      chk({tag, "_w_wdsel"}, 64'(w_wdsel), 64'(m_wd[S-1]));
      chk({tag, "_retired"}, 64'(retired_cnt), 64'(m_cnt));
      chk({tag, "_retired_small"}, 64'(sm_retired), 64'(m_cnt_s));
   endtask

   task automatic cycle(input string tag, input logic [31:0] ins, input logic v,
                        input logic [1:0] trs, input logic [1:0] trt, input logic fl);
      bit st;
      int a3, t0, rw, wd;
      d_instr = ins; d_valid = v; d_tuse_rs = trs; d_tuse_rt = trt; flush = fl;
      @(negedge clk);
      st = exp_stall();
      obs_stall = stall_req;
      chk({tag, "_stall"}, 64'(stall_req), 64'(st));
      @(posedge clk);
      m_cnt   = m_cnt + 32'(m_valid[S-1]);
      m_cnt_s = m_cnt_s + 3'(m_valid[S-1]);
      for (int i = S - 1; i > 0; i--) begin
         m_valid[i] = m_valid[i-1]; m_a3[i] = m_a3[i-1]; m_t0[i] = m_t0[i-1];
         m_rw[i] = m_rw[i-1]; m_wd[i] = m_wd[i-1];
      end
      if (fl || st || !v) begin
         clr_slot(0);
      end else begin
         ref_decode(ins, a3, t0, rw, wd);
         m_valid[0] = 1; m_a3[0] = a3; m_t0[0] = t0; m_rw[0] = rw; m_wd[0] = wd;
      end
      if (fl) for (int i = 0; i < S; i++) clr_slot(i);
      #1;
      check_state(tag);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0] a, b, c;
      a = 5'($urandom_range(0, 7));
      b = 5'($urandom_range(0, 7));
      c = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 16))
         0:  return {6'h00, a, b, c, 5'd0, 6'h21};
         1:  return {6'h00, a, b, c, 5'd3, 6'h00};
         2:  return {6'h0d, a, b, 16'h00ff};
         3:  return {6'h0f, 5'd0, b, 16'h1234};
         4:  return {6'h23, a, b, 16'h0004};
         5:  return {6'h20, a, b, 16'h0001};
         6:  return {6'h2b, a, b, 16'h0008};
         7:  return {6'h04, a, b, 16'h0002};
         8:  return {6'h03, 26'h40};
         9:  return {6'h00, a, 5'd0, c, 5'd0, 6'h09};
         10: return {6'h10, 5'h00, b, c, 11'd0};
         11: return {6'h10, 5'h04, b, c, 11'd0};
         12: return 32'h4200_0018;
         13: return {6'h00, 10'd0, c, 5'd0, 6'h12};
         14: return {6'h00, 10'd0, c, 5'd0, 6'h10};
         15: return {6'h00, a, b, 10'd0, 6'h18};
         default: return {6'h3f, a, b, 16'h0000};
      endcase
   endfunction

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] ADDU3 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
   localparam logic [31:0] LW5   = {6'h23, 5'd0, 5'd5, 16'h0004};
   localparam logic [31:0] DEP5  = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h21};
   localparam logic [31:0] JAL   = {6'h03, 26'h100};
   localparam logic [31:0] DEP31 = {6'h00, 5'd31, 5'd0, 5'd4, 5'd0, 6'h21};
   localparam logic [31:0] ORI6  = {6'h0d, 5'd0, 5'd6, 16'h0001};
   localparam logic [31:0] ORI7  = {6'h0d, 5'd0, 5'd7, 16'h0001};
   localparam logic [31:0] MFLO7 = {6'h00, 10'd0, 5'd7, 5'd0, 6'h12};

   initial begin
      bit [31:0] pre;
      model_clear();
      #1;
      check_state("reset_init");
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // addu $3 travels to W with Tnew 1
      cycle("t2_e", ADDU3, 1'b1, 2'd3, 2'd3, 1'b0);
      chk("t2_slot0_a3", 64'(slot_a3[4:0]), 64'd3);
      chk("t2_slot0_tnew", 64'(slot_tnew[1:0]), 64'd1);
      cycle("t2_m", NOP, 1'b0, 2'd3, 2'd3, 1'b0);
      cycle("t2_w", NOP, 1'b0, 2'd3, 2'd3, 1'b0);
      chk("t2_w_a3", 64'(w_a3), 64'd3);
      chk("t2_w_rw", 64'(w_rw), 64'd1);
      chk("t2_w_wdsel", 64'(w_wdsel), 64'd0);

      // load-use: two stall cycles with a bubble injected into slot 0
      cycle("t3_lw", LW5, 1'b1, 2'd3, 2'd3, 1'b0);
      chk("t3_lw_tnew", 64'(slot_tnew[1:0]), 64'd2);
      cycle("t3_s1", DEP5, 1'b1, 2'd0, 2'd3, 1'b0);
      chk("t3_s1_stall", 64'(obs_stall), 64'd1);
      chk("t3_s1_bubble", 64'(slot_rw[0]), 64'd0);
      cycle("t3_s2", DEP5, 1'b1, 2'd0, 2'd3, 1'b0);
      chk("t3_s2_stall", 64'(obs_stall), 64'd1);
      chk("t3_s2_bubble", 64'(slot_a3[4:0]), 64'd0);
      cycle("t3_go", DEP5, 1'b1, 2'd0, 2'd3, 1'b0);
      chk("t3_go_stall", 64'(obs_stall), 64'd0);
      chk("t3_go_slot0", 64'(slot_a3[4:0]), 64'd6);

      // jal has Tnew 0, so an immediate consumer never stalls
      cycle("t4_jal", JAL, 1'b1, 2'd3, 2'd3, 1'b0);
      chk("t4_jal_a3", 64'(slot_a3[4:0]), 64'd31);
      chk("t4_jal_tnew", 64'(slot_tnew[1:0]), 64'd0);
      cycle("t4_dep", DEP31, 1'b1, 2'd0, 2'd0, 1'b0);
      chk("t4_dep_stall", 64'(obs_stall), 64'd0);
      cycle("t4_w", NOP, 1'b0, 2'd3, 2'd3, 1'b0);
      chk("t4_w_wdsel", 64'(w_wdsel), 64'd2);
      chk("t4_w_a3", 64'(w_a3), 64'd31);

      // flush together with a stall: everything empties, final slot still retires
      cycle("t5_f1", ORI6, 1'b1, 2'd3, 2'd3, 1'b0);
      cycle("t5_f2", ORI7, 1'b1, 2'd3, 2'd3, 1'b0);
      cycle("t5_f3", LW5, 1'b1, 2'd3, 2'd3, 1'b0);
      pre = m_cnt;
      cycle("t5_flush", DEP5, 1'b1, 2'd0, 2'd3, 1'b1);
      chk("t5_stall_seen", 64'(obs_stall), 64'd1);
      chk("t5_rw_empty", 64'(slot_rw), 64'd0);
      chk("t5_a3_empty", 64'(slot_a3), 64'd0);
      chk("t5_retired_plus1", 64'(retired_cnt), 64'(pre + 32'd1));

      // mflo writes only when HI/LO support is built in
      cycle("t6_mflo", MFLO7, 1'b1, 2'd3, 2'd3, 1'b0);
      cycle("t6_m", NOP, 1'b0, 2'd3, 2'd3, 1'b0);
      cycle("t6_w", NOP, 1'b0, 2'd3, 2'd3, 1'b0);
      chk("t6_mflo_w_rw", 64'(w_rw), HILO ? 64'd1 : 64'd0);
      chk("t6_mflo_w_a3", 64'(w_a3), HILO ? 64'd7 : 64'd0);

      // narrow counter wraps from all-ones to zero
      for (int k = 0; k < 3; k++) cycle("t6_fill", NOP, 1'b1, 2'd3, 2'd3, 1'b0);
      for (int k = 0; k < 20 && m_cnt_s != 3'd7; k++) cycle("t6_fill", NOP, 1'b1, 2'd3, 2'd3, 1'b0);
      chk("t6_small_at_max", 64'(sm_retired), 64'd7);
      cycle("t6_wrap", NOP, 1'b1, 2'd3, 2'd3, 1'b0);
      chk("t6_small_wrapped", 64'(sm_retired), 64'd0);

      // asynchronous reset mid-stream with every slot occupied
      cycle("t1_a", ORI6, 1'b1, 2'd3, 2'd3, 1'b0);
      cycle("t1_b", ORI7, 1'b1, 2'd3, 2'd3, 1'b0);
      cycle("t1_c", ADDU3, 1'b1, 2'd3, 2'd3, 1'b0);
      chk("t1_full", 64'(slot_rw), 64'h7);
      #2 reset = 1'b1;
      #1;
      chk("t1_rst_rw", 64'(slot_rw), 64'd0);
      chk("t1_rst_a3", 64'(slot_a3), 64'd0);
      chk("t1_rst_tnew", 64'(slot_tnew), 64'd0);
      chk("t1_rst_cnt", 64'(retired_cnt), 64'd0);
      chk("t1_rst_stall", 64'(stall_req), 64'd0);
      model_clear();
      check_state("t1_rst");
      d_valid = 1'b0; flush = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // random stream against the model
      for (int n = 0; n < 400; n++) begin
         cycle("rnd", rand_instr(), ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
